// File: rtl/lock_pkg.sv
// Shared types and constants for the combination-lock digit entry stage.
package lock_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        HELD,
        RELEASE
    } entry_state_t;

    localparam int unsigned DIGIT_MAX   = 9;
    localparam int unsigned SEQ_LEN_DEF = 6;
    localparam int unsigned DIGIT_W     = 10;
    localparam int unsigned COUNT_W     = 3;
    localparam int unsigned CNT_W       = 16;

endpackage

// File: rtl/lock_digit_entry_if.sv
// Digit bus between the entry stage (master) and the lock FSM (slave).
interface lock_digit_entry_if;
    import lock_pkg::*;

    logic [DIGIT_W-1:0] digit_out;
    logic               digit_valid;
    logic               digit_err;
    logic [COUNT_W-1:0] digit_count;
    logic               seq_done;
    logic               clear;

    modport master (
        output digit_out, digit_valid, digit_err, digit_count, seq_done,
        input  clear
    );

    modport slave (
        input  digit_out, digit_valid, digit_err, digit_count, seq_done,
        output clear
    );

endinterface

// File: rtl/sync2.sv
// Two-flop synchroniser of configurable width and reset value.
module sync2 #(
    parameter int unsigned      WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/lock_digit_entry.sv
// Synchronises switches and ENTER key, debounces the key and emits one digit strobe per press.
// Optional range check enabled by defining LOCK_DIGIT_RANGE_CHECK_EN.
module lock_digit_entry
    import lock_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned SEQ_LEN         = SEQ_LEN_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DIGIT_W-1:0] sw_in,
    input  logic               key_n,
    lock_digit_entry_if.master digit
);

    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [COUNT_W-1:0] COUNT_END = COUNT_W'(SEQ_LEN);

    logic               key_s;
    logic [DIGIT_W-1:0] sw_s;

    entry_state_t       state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               accept_c;

    logic [DIGIT_W-1:0] out_q;
    logic               valid_q;
    logic [COUNT_W-1:0] count_q;
    logic               done_q;

    sync2 #(.WIDTH(1), .RST_VAL(1'b1)) u_key_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (key_n),
        .q     (key_s)
    );

    sync2 #(.WIDTH(DIGIT_W), .RST_VAL('0)) u_sw_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sw_in),
        .q     (sw_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Debounce: a level must hold for DEBOUNCE_CYCLES samples; any glitch restarts the run.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept_c  = 1'b0;
        case (state)
            IDLE: begin
                if (!key_s) begin
                    state_nxt = PRESS;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            PRESS: begin
                if (key_s) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = HELD;
                    accept_c  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (key_s) begin
                    state_nxt = RELEASE;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            RELEASE: begin
                if (!key_s) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef LOCK_DIGIT_RANGE_CHECK_EN
    logic err_q;
    wire  bad_c = (sw_s > DIGIT_W'(DIGIT_MAX));
`else
    wire  bad_c = 1'b0;
`endif

    // Clear beats a coincident accept; a full sequence swallows further presses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
            done_q  <= 1'b0;
`ifdef LOCK_DIGIT_RANGE_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
`ifdef LOCK_DIGIT_RANGE_CHECK_EN
            err_q   <= 1'b0;
`endif
            if (digit.clear) begin
                count_q <= '0;
                done_q  <= 1'b0;
            end else if (accept_c && !done_q) begin
                out_q   <= sw_s;
                valid_q <= !bad_c;
`ifdef LOCK_DIGIT_RANGE_CHECK_EN
                err_q   <= bad_c;
`endif
                count_q <= count_q + COUNT_W'(1);
                done_q  <= (count_q + COUNT_W'(1)) == COUNT_END;
            end
        end
    end

    assign digit.digit_out   = out_q;
    assign digit.digit_valid = valid_q;
    assign digit.digit_count = count_q;
    assign digit.seq_done    = done_q;
`ifdef LOCK_DIGIT_RANGE_CHECK_EN
    assign digit.digit_err   = err_q;
`else
    assign digit.digit_err   = 1'b0;
`endif

endmodule

// File: tb/tb_lock_digit_entry.sv
// Bench for lock_digit_entry: run-length press model checked every cycle plus literal checks.
module tb_lock_digit_entry;
    import lock_pkg::*;

    localparam int unsigned D  = 4;
    localparam int unsigned SL = 6;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_n = 1'b1;
    logic [9:0] sw_in = '0;

    lock_digit_entry_if dif ();

    lock_digit_entry #(.DEBOUNCE_CYCLES(D), .SEQ_LEN(SL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sw_in (sw_in),
        .key_n (key_n),
        .digit (dif.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Model: inputs seen two edges late; a press/release is a run of D opposite-level samples.
    logic [9:0] hist_sw [0:1];
    logic       hist_key [0:1];
    bit         pressed;
    int         run;
    logic       m_key;
    logic [9:0] m_sw;
    bit         m_acc;
    logic [9:0] m_out;
    logic       m_valid, m_err, m_done;
    int         m_count;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_key[0] = 1'b1; hist_key[1] = 1'b1;
            hist_sw[0]  = '0;   hist_sw[1]  = '0;
            pressed = 0; run = 0;
            m_out = '0; m_valid = 0; m_err = 0; m_done = 0; m_count = 0;
        end else begin
            m_key = hist_key[1];
            m_sw  = hist_sw[1];
            hist_key[1] = hist_key[0]; hist_key[0] = key_n;
            hist_sw[1]  = hist_sw[0];  hist_sw[0]  = sw_in;
            m_acc = 0;
            if ((m_key == 1'b0) == pressed) begin
                run = 0;
            end else begin
                run++;
                if (run == D) begin
                    pressed = !pressed;
                    run = 0;
                    m_acc = pressed;
                end
            end
            m_valid = 0;
            m_err   = 0;
            if (dif.clear) begin
                m_count = 0;
                m_done  = 0;
            end else if (m_acc && !m_done) begin
                m_out = m_sw;
                m_count++;
                m_done = (m_count == SL);
`ifdef LOCK_DIGIT_RANGE_CHECK_EN
                if (m_sw > 9) m_err = 1; else m_valid = 1;
`else
                m_valid = 1;
`endif
            end
        end
    end

    always @(negedge clk) begin
        check("cyc_valid", 32'(dif.digit_valid), 32'(m_valid));
        check("cyc_err",   32'(dif.digit_err),   32'(m_err));
        check("cyc_out",   32'(dif.digit_out),   32'(m_out));
        check("cyc_count", 32'(dif.digit_count), 32'(m_count));
        check("cyc_done",  32'(dif.seq_done),    32'(m_done));
    end

    int         nstrobe = 0;
    int         nerr    = 0;
    logic [9:0] got[$];

    always @(negedge clk) begin
        if (dif.digit_valid === 1'b1) begin
            nstrobe++;
            got.push_back(dif.digit_out);
        end
        if (dif.digit_err === 1'b1) nerr++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic press(input logic [9:0] val, input int hold);
        sw_in = val;
        tick(3);
        key_n = 1'b0;
        tick(hold);
        key_n = 1'b1;
        tick(2 * D + 6);
    endtask

    int         s0, e0;
    logic [9:0] exp_seq [0:5];

    initial begin
        exp_seq[0] = 10'd7; exp_seq[1] = 10'd2; exp_seq[2] = 10'd2;
        exp_seq[3] = 10'd2; exp_seq[4] = 10'd9; exp_seq[5] = 10'd7;
        dif.clear = 1'b0;
        tick(3);
        check("reset_out",   32'(dif.digit_out), 0);
        check("reset_count", 32'(dif.digit_count), 0);
        check("reset_done",  32'(dif.seq_done), 0);
        rst_n = 1'b1;
        tick(2);

        // Clean press: strobe only after edge D+2 counted from the first low sample.
        sw_in = 10'd7;
        tick(3);
        key_n = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("clean_early", 32'(dif.digit_valid), 0);
        @(posedge clk);
        @(negedge clk);
        check("clean_valid", 32'(dif.digit_valid), 1);
        check("clean_out",   32'(dif.digit_out), 7);
        check("clean_count", 32'(dif.digit_count), 1);
        tick(4);
        key_n = 1'b1;
        tick(2 * D + 6);

        // Three 2-cycle bounces, then held for 50 cycles.
        sw_in = 10'd2;
        tick(3);
        s0 = nstrobe;
        repeat (3) begin
            key_n = 1'b0; tick(2);
            key_n = 1'b1; tick(2);
        end
        key_n = 1'b0;
        tick(50);
        key_n = 1'b1;
        tick(2 * D + 6);
        check("bounce_one", 32'(nstrobe - s0), 1);

        press(10'd2, 10);
        press(10'd2, 10);
        press(10'd9, 10);
        press(10'd7, 10);
        check("seq_len", 32'(got.size()), 6);
        for (int i = 0; i < 6; i++)
            if (i < got.size()) check($sformatf("seq_val%0d", i), 32'(got[i]), 32'(exp_seq[i]));
        check("seq_done",  32'(dif.seq_done), 1);
        check("seq_count", 32'(dif.digit_count), 6);

        s0 = nstrobe;
        press(10'd5, 10);
        check("swallow_none", 32'(nstrobe - s0), 0);
        check("swallow_out",  32'(dif.digit_out), 7);
        check("swallow_count", 32'(dif.digit_count), 6);

        dif.clear = 1'b1;
        tick(1);
        dif.clear = 1'b0;
        check("clear_count", 32'(dif.digit_count), 0);
        check("clear_done",  32'(dif.seq_done), 0);

        // Out-of-range value.
        s0 = nstrobe;
        e0 = nerr;
        press(10'd12, 10);
        check("big_count", 32'(dif.digit_count), 1);
        check("big_out",   32'(dif.digit_out), 12);
`ifdef LOCK_DIGIT_RANGE_CHECK_EN
        check("big_err",   32'(nerr - e0), 1);
        check("big_valid", 32'(nstrobe - s0), 0);
`else
        check("big_err",   32'(nerr - e0), 0);
        check("big_valid", 32'(nstrobe - s0), 1);
`endif

        // Clear on the accept edge.
        s0 = nstrobe;
        sw_in = 10'd3;
        tick(3);
        key_n = 1'b0;
        tick(5);
        dif.clear = 1'b1;
        tick(1);
        dif.clear = 1'b0;
        check("clracc_valid", 32'(dif.digit_valid), 0);
        check("clracc_count", 32'(dif.digit_count), 0);
        check("clracc_out",   32'(dif.digit_out), 12);
        tick(3);
        key_n = 1'b1;
        tick(2 * D + 6);
        check("clracc_none", 32'(nstrobe - s0), 0);

        // Reset while debouncing a press.
        press(10'd1, 10);
        sw_in = 10'd4;
        tick(3);
        key_n = 1'b0;
        tick(4);
        s0 = nstrobe;
        rst_n = 1'b0;
        #1;
        check("rst_out",   32'(dif.digit_out), 0);
        check("rst_valid", 32'(dif.digit_valid), 0);
        check("rst_count", 32'(dif.digit_count), 0);
        check("rst_done",  32'(dif.seq_done), 0);
        key_n = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(20);
        check("rst_none", 32'(nstrobe - s0), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
